// File: rtl/pc_pkg.sv
// Shared PC constants and types, also used by the control unit and decoder.
package pc_pkg;

  localparam int unsigned WIDTH = 64;
  localparam logic [WIDTH-1:0] RESET_VECTOR = 64'h0;
  localparam int unsigned PC_INCREMENT = 4;

  typedef logic [WIDTH-1:0] pc_t;

  // Next-address source selected by soma_imm
  typedef enum logic {
    SelSeq = 1'b0,
    SelImm = 1'b1
  } next_sel_e;

  // Instruction fetch addresses must be word aligned
  function automatic logic addr_misaligned(input logic [1:0] low_bits);
    return low_bits != 2'b00;
  endfunction

endpackage

// File: rtl/program_counter_unit_if.sv
// Control-unit <-> PC datapath bundle. The control unit is the master.
interface program_counter_unit_if #(
  parameter int unsigned WIDTH = pc_pkg::WIDTH
);

  logic             atualiza_pc;
  logic             soma_imm;
  logic [WIDTH-1:0] imm_pc;
  logic [WIDTH-1:0] doutPC;
  logic [WIDTH-1:0] next_pc;
  logic             misaligned;

  modport master (
    output atualiza_pc,
    output soma_imm,
    output imm_pc,
    input  doutPC,
    input  next_pc,
    input  misaligned
  );

  modport slave (
    input  atualiza_pc,
    input  soma_imm,
    input  imm_pc,
    output doutPC,
    output next_pc,
    output misaligned
  );

endinterface

// File: rtl/pc_adder.sv
// Combinational next-address adder: PC + step or PC + immediate, modulo 2^WIDTH.
module pc_adder #(
  parameter int unsigned WIDTH        = pc_pkg::WIDTH,
  parameter int unsigned PC_INCREMENT = pc_pkg::PC_INCREMENT
) (
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] imm,
  input  logic             soma_imm,
  output logic [WIDTH-1:0] next_pc
);
  import pc_pkg::*;

  localparam logic [WIDTH-1:0] Step = WIDTH'(PC_INCREMENT);

  logic [WIDTH-1:0] offset;

  // Select the offset, then add; carry out is intentionally dropped
  always_comb begin
    offset = Step;
    unique case (next_sel_e'(soma_imm))
      SelSeq:  offset = Step;
      SelImm:  offset = imm;
      default: offset = Step;
    endcase
    next_pc = pc + offset;
  end

endmodule

// File: rtl/program_counter_unit.sv
// Program counter register with its next-address adder and misalignment flag.
module program_counter_unit #(
  parameter int unsigned     WIDTH        = pc_pkg::WIDTH,
  parameter logic [WIDTH-1:0] RESET_VECTOR = pc_pkg::RESET_VECTOR,
  parameter int unsigned     PC_INCREMENT = pc_pkg::PC_INCREMENT
) (
  input  logic                   clk,
  input  logic                   reset,
  program_counter_unit_if.slave  pc_bus
);
  import pc_pkg::*;

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;
  logic [WIDTH-1:0] next_addr;

  pc_adder #(
    .WIDTH        (WIDTH),
    .PC_INCREMENT (PC_INCREMENT)
  ) u_pc_adder (
    .pc       (pc_q),
    .imm      (pc_bus.imm_pc),
    .soma_imm (pc_bus.soma_imm),
    .next_pc  (next_addr)
  );

  // Load the adder result only on an update strobe; otherwise hold
  always_comb begin
    pc_d = pc_q;
    if (pc_bus.atualiza_pc) begin
      pc_d = next_addr;
    end
  end

  // PC register; reset is asynchronous and overrides any update
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= RESET_VECTOR;
    end else begin
      pc_q <= pc_d;
    end
  end

  // Misaligned targets are still loaded; the flag is advisory for the control unit
  assign pc_bus.doutPC     = pc_q;
  assign pc_bus.next_pc    = next_addr;
  assign pc_bus.misaligned = addr_misaligned(next_addr[1:0]);

endmodule

// File: tb/tb_program_counter_unit.sv
// Self-checking bench for program_counter_unit with a behavioural PC model.
module tb_program_counter_unit;
  import pc_pkg::*;

  logic clk;
  logic reset;

  program_counter_unit_if bus ();

  program_counter_unit dut (
    .clk    (clk),
    .reset  (reset),
    .pc_bus (bus)
  );

  int unsigned n_checks;
  int unsigned n_fail;

  // Model state: the architectural PC value
  pc_t exp_pc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", tag, got, exp);
    end
  endtask

  // Model of the next fetch address from the architectural rules
  function automatic pc_t model_target(input pc_t pc, input logic sel, input pc_t imm);
    logic [64:0] sum;
    sum = {1'b0, pc} + {1'b0, (sel ? imm : pc_t'(4))};
    return pc_t'(sum % (65'd1 << 64));
  endfunction

  function automatic logic model_misaligned(input pc_t addr);
    return (addr % 4) != 0;
  endfunction

  // Check combinational outputs against the model for the current inputs
  task automatic check_comb(input string tag);
    pc_t t;
    t = model_target(exp_pc, bus.soma_imm, bus.imm_pc);
    check({tag, "_next"}, bus.next_pc, t);
    check({tag, "_mis"}, {63'd0, bus.misaligned}, {63'd0, model_misaligned(t)});
  endtask

  // One update cycle: drive on negedge, check before and after the rising edge
  task automatic step(input logic upd, input logic sel, input pc_t imm, input string tag);
    @(negedge clk);
    bus.atualiza_pc = upd;
    bus.soma_imm    = sel;
    bus.imm_pc      = imm;
    #1;
    check_comb(tag);
    @(posedge clk);
    if (upd) exp_pc = model_target(exp_pc, sel, imm);
    #1;
    check({tag, "_pc"}, bus.doutPC, exp_pc);
    bus.atualiza_pc = 1'b0;
  endtask

  initial begin
    n_checks        = 0;
    n_fail          = 0;
    reset           = 1'b1;
    bus.atualiza_pc = 1'b0;
    bus.soma_imm    = 1'b0;
    bus.imm_pc      = '0;
    exp_pc          = RESET_VECTOR;

    // Async reset mid-cycle with update requested
    repeat (2) @(posedge clk);
    #2;
    bus.atualiza_pc = 1'b1;
    reset = 1'b0;
    #1;
    check("reset_async", bus.doutPC, 64'h0);
    // Reset held across a rising edge with update high
    @(posedge clk);
    #1;
    check("reset_collide", bus.doutPC, 64'h0);
    @(negedge clk);
    bus.atualiza_pc = 1'b0;
    reset = 1'b1;
    #1;
    check("reset_next", bus.next_pc, 64'h4);
    check("reset_mis", {63'd0, bus.misaligned}, 64'h0);

    // Sequential pulses with idle cycles between
    step(1'b1, 1'b0, '0, "seq1");
    check("seq1_val", bus.doutPC, 64'h4);
    step(1'b0, 1'b1, 64'h100, "idle1");
    check("idle1_val", bus.doutPC, 64'h4);
    step(1'b1, 1'b0, '0, "seq2");
    check("seq2_val", bus.doutPC, 64'h8);
    step(1'b0, 1'b0, '0, "idle2");
    step(1'b1, 1'b0, '0, "seq3");
    check("seq3_val", bus.doutPC, 64'hC);

    // Forward then backward branch
    step(1'b1, 1'b1, 64'h10, "fwd");
    check("fwd_val", bus.doutPC, 64'h1C);
    step(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, "bwd");
    check("bwd_val", bus.doutPC, 64'h14);

    // Held high three cycles advances three times
    @(negedge clk);
    bus.atualiza_pc = 1'b1;
    bus.soma_imm    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    exp_pc = 64'h20;
    check("held3", bus.doutPC, exp_pc);
    bus.atualiza_pc = 1'b0;

    // Reach the top of the address space, then wrap
    step(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC - 64'h20, "to_top");
    check("top_val", bus.doutPC, 64'hFFFF_FFFF_FFFF_FFFC);
    step(1'b1, 1'b0, '0, "wrap");
    check("wrap_val", bus.doutPC, 64'h0);

    // Misaligned target is flagged but still loaded
    @(negedge clk);
    bus.soma_imm = 1'b1;
    bus.imm_pc   = 64'h2;
    #1;
    check("mis_flag", {63'd0, bus.misaligned}, 64'h1);
    step(1'b1, 1'b1, 64'h2, "mis_load");
    check("mis_val", bus.doutPC, 64'h2);

    // Randomised cycles with occasional asynchronous reset
    for (int i = 0; i < 300; i++) begin
      logic [63:0] imm;
      imm = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 0) imm[1:0] = 2'b00;
      if ($urandom_range(0, 3) == 0) imm = 64'($signed($urandom_range(0, 64)) - 32);
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), imm, "rnd");
      if ($urandom_range(0, 24) == 0) begin
        #1;
        reset = 1'b0;
        #1;
        exp_pc = RESET_VECTOR;
        check("rnd_reset", bus.doutPC, exp_pc);
        reset = 1'b1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/program_counter_unit.md
# program_counter_unit

Program-counter datapath for the RISC-V core: a 64-bit PC register plus its next-address adder. It is driven by the control unit's fetch-state update strobe and branch/jump select. It holds the current fetch address. Each update step advances the PC either sequentially (+4) or PC-relative (+immediate).

## Interface
Parameters:
- `WIDTH`, 64, PC and immediate width in bits.
- `RESET_VECTOR`, 64'h0, PC value loaded by reset.
- `PC_INCREMENT`, 4, sequential step in bytes.

Ports:
- `clk`  input  1  single system clock; all state changes on its rising edge.
- `reset`  input  1  asynchronous, active-low reset (0 = reset asserted).
- `atualiza_pc`  input  1  update enable; PC loads next address at the rising clk edge when 1.
- `soma_imm`  input  1  next-address select: 0 = PC + PC_INCREMENT, 1 = PC + `imm_pc`.
- `imm_pc`  input  WIDTH  signed immediate offset, already sign-extended by the decoder.
- `doutPC`  output  WIDTH  current PC (registered).
- `next_pc`  output  WIDTH  combinational next address (adder output).
- `misaligned`  output  1  combinational; 1 when `next_pc[1:0] != 2'b00`.

## Operation
- Next-address adder (combinational):
  - `next_pc = doutPC + (soma_imm ? imm_pc : PC_INCREMENT)`.
  - Two's-complement add, truncated to WIDTH bits (modulo 2^WIDTH wrap-around, no carry out).
  - Negative immediates yield backward targets.
- PC register:
  - `reset`=0 forces `doutPC = RESET_VECTOR` immediately, independent of `clk`.
  - Otherwise, at each rising `clk` with `atualiza_pc`=1: `doutPC <= next_pc`.
  - With `atualiza_pc`=0 the PC holds.
- `misaligned` is advisory only. A misaligned target is still loaded unchanged; trapping belongs to the control unit.
- No X-propagation guarding: undefined `soma_imm`/`imm_pc` only matter when `atualiza_pc`=1.

## Timing
- Reset values:
  - `doutPC = RESET_VECTOR`.
  - `next_pc = RESET_VECTOR + 4` when `soma_imm`=0.
  - `misaligned` follows `next_pc`.
- Latency: one clock from `atualiza_pc` sampled high to the new `doutPC`. `next_pc`/`misaligned` settle combinationally in the same cycle.
- The control unit holds `atualiza_pc` high for exactly one cycle per instruction (fetch state). If it is held high for N cycles, the PC advances N times.
- `soma_imm`/`imm_pc` are sampled at the same edge as `atualiza_pc`. Changes between edges have no effect on `doutPC`.
- Reset asserted simultaneously with an update edge: reset wins, `doutPC = RESET_VECTOR`.
- Reset asserted mid-operation: PC returns to RESET_VECTOR asynchronously.
- After reset release, the first update occurs at the first rising edge with `atualiza_pc`=1.
- Wrap-around: PC `64'hFFFF_FFFF_FFFF_FFFC` + 4 gives `64'h0`, with no flag.

## Structure
- Shared package `pc_pkg`: `WIDTH`, `RESET_VECTOR`, `PC_INCREMENT` constants and a `pc_t` (logic [WIDTH-1:0]) typedef, shared with the control unit and decoder.
- One sub-module, `pc_adder`: the combinational next-address adder and select mux (inputs current PC, imm, select; output next address).
- The top level holds only the PC register, the `misaligned` decode and wiring.

## Test plan
- Reset: drive `reset`=0 mid-cycle with `atualiza_pc`=1 -> `doutPC`=0 immediately, before any clk edge; after release `next_pc`=4.
- Sequential: `soma_imm`=0, three one-cycle `atualiza_pc` pulses from 0 -> `doutPC` 4, 8, 0xC; idle cycles between pulses hold the value.
- Forward branch: PC=8, `soma_imm`=1, `imm_pc`=0x10, pulse -> `doutPC`=0x18, `misaligned`=0 beforehand.
- Backward branch: PC=0x18, `imm_pc`=64'hFFFF_FFFF_FFFF_FFF8 (-8), pulse -> `doutPC`=0x10.
- Wrap and misalignment:
  - Reach PC=64'hFFFF_FFFF_FFFF_FFFC (RESET_VECTOR override or offset), `soma_imm`=0, pulse -> `doutPC`=0.
  - Then `imm_pc`=2, `soma_imm`=1 -> `misaligned`=1 combinationally; pulse -> `doutPC`=2.
- Reset/update collision: `reset` low across a rising clk with `atualiza_pc`=1 -> `doutPC` stays 0.
